// File: rtl/spi_master_tx.sv
// SPI mode-0 transmit master: one DATA_W-bit word per frame, MSB first, SCLK period 2*CLK_DIV clk cycles.
// Optional miso capture is built when SPI_MASTER_TX_MISO_CAPTURE_EN is defined; otherwise rx outputs are tied to 0.
module spi_master_tx #(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_valid_in,
    output logic              tx_ready_out,
    output logic              sclk_out,
    output logic              mosi_out,
    output logic              ss_n_out,
    input  logic              miso_in,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_valid_out
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    // GAP is one cycle shorter than CLK_DIV: together with the single IDLE
    // accept cycle, ss_n stays high exactly CLK_DIV cycles between held frames.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  div_cnt, div_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              sclk_q, sclk_nxt;
    logic [DATA_W-1:0] tx_shreg, tx_shreg_nxt;
    logic              div_end;
    logic              sclk_rise;
    logic              frame_done;
    logic              ss_active;

    assign div_end   = (div_cnt == DIV_LAST);
    assign ss_active = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    assign tx_ready_out = (state == IDLE);
    assign ss_n_out     = !ss_active;
    assign sclk_out     = sclk_q;
    assign mosi_out     = ss_active & tx_shreg[DATA_W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk_q   <= 1'b0;
            tx_shreg <= '0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sclk_q   <= sclk_nxt;
            tx_shreg <= tx_shreg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        bit_cnt_nxt  = bit_cnt;
        sclk_nxt     = sclk_q;
        tx_shreg_nxt = tx_shreg;
        sclk_rise    = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_valid_in) begin
                    state_nxt    = SETUP;
                    div_cnt_nxt  = '0;
                    bit_cnt_nxt  = '0;
                    tx_shreg_nxt = tx_data_in;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_nxt   = SHIFT;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = !sclk_q;
                    // mosi advances on the same edge that drops sclk, so every bit
                    // is settled for a full low phase before the slave samples it.
                    if (!sclk_q) begin
                        sclk_rise = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        bit_cnt_nxt  = bit_cnt + 1'b1;
                        tx_shreg_nxt = tx_shreg << 1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (div_end) begin
                    frame_done  = 1'b1;
                    div_cnt_nxt = '0;
                    state_nxt   = (CLK_DIV == 1) ? IDLE : GAP;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    state_nxt   = IDLE;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_MASTER_TX_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_shreg;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;

    // The pulse is registered off the HOLD-exit edge, so it lands on the first ss_n-high cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_shreg   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= frame_done;
            if (sclk_rise) begin
                rx_shreg <= (rx_shreg << 1) | DATA_W'(miso_in);
            end
            if (frame_done) begin
                rx_data_q <= rx_shreg;
            end
        end
    end

    assign rx_data_out  = rx_data_q;
    assign rx_valid_out = rx_valid_q;
`else
    logic unused_rx;
    assign unused_rx    = ^{miso_in, sclk_rise, frame_done};
    assign rx_data_out  = '0;
    assign rx_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: a 4-bit/CLK_DIV=4 instance and an 8-bit/CLK_DIV=1 instance,
// each watched by a frame monitor that also plays the slave on miso.
module tb_spi_master_tx;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] rx;
    } frame_t;

`ifdef SPI_MASTER_TX_MISO_CAPTURE_EN
    localparam logic CAPTURE = 1'b1;
`else
    localparam logic CAPTURE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tx_data0;
    logic [7:0] tx_data1;
    logic       tx_valid [2];
    logic       miso [2];
    logic       tx_ready [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       ss_n [2];
    logic       rx_valid [2];
    logic [3:0] rx_data0;
    logic [7:0] rx_data1;

    int checks = 0;
    int failures = 0;

    frame_t sb0[$];
    frame_t sb1[$];

    always #5 clk = ~clk;

    spi_master_tx #(.DATA_W(4), .CLK_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .tx_data_in(tx_data0), .tx_valid_in(tx_valid[0]), .tx_ready_out(tx_ready[0]),
        .sclk_out(sclk[0]), .mosi_out(mosi[0]), .ss_n_out(ss_n[0]), .miso_in(miso[0]),
        .rx_data_out(rx_data0), .rx_valid_out(rx_valid[0])
    );

    spi_master_tx #(.DATA_W(8), .CLK_DIV(1)) dut8 (
        .clk(clk), .reset(reset),
        .tx_data_in(tx_data1), .tx_valid_in(tx_valid[1]), .tx_ready_out(tx_ready[1]),
        .sclk_out(sclk[1]), .mosi_out(mosi[1]), .ss_n_out(ss_n[1]), .miso_in(miso[1]),
        .rx_data_out(rx_data1), .rx_valid_out(rx_valid[1])
    );

    function automatic int widthOf(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int divOf(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Monitor state, one slot per instance
    int         low_cnt [2];
    int         rises [2];
    int         high_cnt [2];
    int         ready_run [2];
    int         frames_done [2] = '{0, 0};
    logic [7:0] mosi_word [2];
    logic [7:0] slave_word [2];
    bit         in_frame [2];
    bit         expect_b2b [2] = '{1'b0, 1'b0};
    logic       prev_ss [2];
    logic       prev_sclk [2];
    logic       prev_ready [2];
    logic       prev_valid [2];

    frame_t     mf;
    logic [7:0] rxd;
    logic [7:0] tmp;
    bit         ended;
    int         w;
    int         d;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            w     = widthOf(i);
            d     = divOf(i);
            rxd   = (i == 0) ? {4'b0, rx_data0} : rx_data1;
            ended = 1'b0;
            if (reset) begin
                in_frame[i]   = 1'b0;
                prev_ss[i]    = 1'b1;
                prev_sclk[i]  = 1'b0;
                prev_ready[i] = 1'b1;
                prev_valid[i] = 1'b0;
                high_cnt[i]   = 0;
                ready_run[i]  = 0;
                miso[i]       = 1'b0;
            end else begin
                if (!ss_n[i] && prev_ss[i]) begin
                    checkOutput("accept_edge", 32'({prev_valid[i], prev_ready[i]}), 32'd3);
                    checkOutput("ready_busy", 32'(tx_ready[i]), 32'd0);
                    if (expect_b2b[i]) begin
                        checkOutput("gap_ss_high", 32'(high_cnt[i]), 32'(d));
                        checkOutput("ready_run", 32'(ready_run[i]), 32'd1);
                        expect_b2b[i] = 1'b0;
                    end
                    in_frame[i]  = 1'b1;
                    low_cnt[i]   = 0;
                    rises[i]     = 0;
                    mosi_word[i] = 8'h00;
                    slave_word[i] = 8'h00;
                    if (i == 0 && sb0.size() > 0) slave_word[i] = sb0[0].rx;
                    if (i == 1 && sb1.size() > 0) slave_word[i] = sb1[0].rx;
                end
                if (!ss_n[i]) begin
                    low_cnt[i]++;
                    if (sclk[i] && !prev_sclk[i]) begin
                        mosi_word[i] = {mosi_word[i][6:0], mosi[i]};
                        rises[i]++;
                    end
                end else if (!prev_ss[i] && in_frame[i]) begin
                    ended = 1'b1;
                    in_frame[i] = 1'b0;
                    frames_done[i]++;
                    mf = '0;
                    if (i == 0 && sb0.size() > 0) mf = sb0.pop_front();
                    else if (i == 1 && sb1.size() > 0) mf = sb1.pop_front();
                    else checkOutput("sb_empty", 32'd1, 32'd0);
                    checkOutput("ss_low_cycles", 32'(low_cnt[i]), 32'((2 * w + 2) * d));
                    checkOutput("sclk_rises", 32'(rises[i]), 32'(w));
                    checkOutput("mosi_word", 32'(mosi_word[i]), 32'(mf.tx));
                    checkOutput("idle_lines", 32'({sclk[i], mosi[i]}), 32'd0);
                    checkOutput("rx_valid", 32'(rx_valid[i]), 32'(CAPTURE));
                    checkOutput("rx_data", 32'(rxd), CAPTURE ? 32'(mf.rx) : 32'd0);
                    high_cnt[i] = 0;
                end
                if (ss_n[i]) high_cnt[i]++;
                if (rx_valid[i] && !ended) checkOutput("rx_valid_spurious", 32'd1, 32'd0);
                if (ss_n[i] && mosi[i]) checkOutput("mosi_idle", 32'(mosi[i]), 32'd0);
                // Slave side: present the next bit ahead of each rising edge; toggle while idle
                if (!ss_n[i] && rises[i] < w) begin
                    tmp     = slave_word[i] >> (w - 1 - rises[i]);
                    miso[i] = tmp[0];
                end else begin
                    miso[i] = ~miso[i];
                end
                ready_run[i]  = tx_ready[i] ? ready_run[i] + 1 : 0;
                prev_ss[i]    = ss_n[i];
                prev_sclk[i]  = sclk[i];
                prev_ready[i] = tx_ready[i];
                prev_valid[i] = tx_valid[i];
            end
        end
    end

    // Called at posedge+#1: drives the word, waits for the accepting edge, then scrambles tx_data
    task automatic applyStimulus(input int i, input logic [7:0] tx, input logic [7:0] slave, input bit hold);
        frame_t f;
        int     n;
        f.tx = tx;
        f.rx = slave;
        if (i == 0) begin
            sb0.push_back(f);
            tx_data0 = tx[3:0];
        end else begin
            sb1.push_back(f);
            tx_data1 = tx;
        end
        tx_valid[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready[i] && n < 500);
        if (!tx_ready[i]) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (i == 0) tx_data0 = ~tx[3:0];
        else tx_data1 = ~tx;
        if (!hold) tx_valid[i] = 1'b0;
    endtask

    task automatic waitFrames(input int i, input int target);
        int n;
        n = 0;
        while (frames_done[i] < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_count", 32'(frames_done[i]), 32'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        tx_valid[0] = 1'b0;
        tx_valid[1] = 1'b0;
        tx_data0    = 4'h0;
        tx_data1    = 8'h00;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ss_n", 32'(ss_n[0]), 32'd1);
        checkOutput("rst_sclk", 32'(sclk[0]), 32'd0);
        checkOutput("rst_mosi", 32'(mosi[0]), 32'd0);
        checkOutput("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data0), 32'd0);
        checkOutput("rst_ready", 32'(tx_ready[0]), 32'd1);
        checkOutput("rst_ss_n8", 32'(ss_n[1]), 32'd1);
        reset = 1'b0;

        applyStimulus(0, 8'h0A, 8'h06, 1'b0);
        waitFrames(0, 1);
        applyStimulus(0, 8'h05, 8'h09, 1'b0);
        waitFrames(0, 2);

        // Held valid: two frames back to back
        applyStimulus(0, 8'h0F, 8'h06, 1'b1);
        @(negedge clk);
        #1;
        expect_b2b[0] = 1'b1;
        applyStimulus(0, 8'h03, 8'h09, 1'b0);
        waitFrames(0, 4);

        // Abort during the second SCLK high phase
        applyStimulus(0, 8'h0C, 8'h05, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(rises[0] == 2 && sclk[0]) && n < 200);
        checkOutput("reach_2nd_high", 32'(rises[0]), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("pre_abort_sclk", 32'(sclk[0]), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_ss_n", 32'(ss_n[0]), 32'd1);
        checkOutput("abort_sclk", 32'(sclk[0]), 32'd0);
        checkOutput("abort_mosi", 32'(mosi[0]), 32'd0);
        checkOutput("abort_ready", 32'(tx_ready[0]), 32'd1);
        void'(sb0.pop_back());
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 8'h09, 8'h0A, 1'b0);
        waitFrames(0, 5);

        // Fast divider, wide word
        applyStimulus(1, 8'hA5, 8'h3C, 1'b0);
        waitFrames(1, 1);

        checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);
        checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
